// File: rtl/ibex_rf_wb_comparator.sv
// Lockstep writeback comparator: buffers main-core register-file writes and
// checks them against the lagging shadow core, requesting a rollback on any
// divergence, FIFO underflow/overflow or head-entry timeout.
module ibex_rf_wb_comparator #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned Depth         = 4,
   parameter int unsigned TimeoutCycles = 16,
   parameter int unsigned HoldoffCycles = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   main_we_i,
   input  logic [4:0]             main_waddr_i,
   input  logic [DataWidth-1:0]   main_wdata_i,
   input  logic                   shadow_we_i,
   input  logic [4:0]             shadow_waddr_i,
   input  logic [DataWidth-1:0]   shadow_wdata_i,
   output logic                   comparator_mismatch_o,
   output logic [3:0]             mismatch_cause_o,
   output logic [7:0]             mismatch_cnt_o,
   output logic [$clog2(Depth):0] fifo_level_o
);

   // Depth must be a power of two (>= 2) so the pointers wrap for free.
   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned LevelW = PtrW + 1;
   localparam int unsigned AgeW   = $clog2(TimeoutCycles + 1);
   localparam int unsigned HoldW  = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;

   typedef enum logic [1:0] {
      COMPARE = 2'd0,
      FLUSH   = 2'd1,
      HOLDOFF = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0]           addr;
      logic [DataWidth-1:0] data;
   } wb_entry_t;

   state_e            state_q, state_d;
   logic [HoldW-1:0]  hold_q, hold_d;

   wb_entry_t         mem [Depth];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LevelW-1:0] level_q;
   logic [AgeW-1:0]   age_q;

   logic [3:0]        cause_q;
   logic [7:0]        cnt_q;
   logic              mismatch_q;

   wb_entry_t         main_entry, shadow_entry, head_entry, cmp_entry;
   logic              fifo_empty, fifo_full;
   logic              push_c, pop_c, bypass_c, detect_c;
   logic [3:0]        cause_c;

   assign main_entry   = '{addr: main_waddr_i,   data: main_wdata_i};
   assign shadow_entry = '{addr: shadow_waddr_i, data: shadow_wdata_i};
   assign head_entry   = mem[rd_ptr_q];
   assign fifo_empty   = (level_q == '0);
   assign fifo_full    = (level_q == LevelW'(Depth));

   // Push/pop decisions and mismatch detection, active only in COMPARE
   always_comb begin
      push_c    = 1'b0;
      pop_c     = 1'b0;
      bypass_c  = 1'b0;
      cause_c   = '0;
      cmp_entry = head_entry;
      if (state_q == COMPARE) begin
         bypass_c  = main_we_i & shadow_we_i & fifo_empty;
         pop_c     = shadow_we_i & ~fifo_empty;
         push_c    = main_we_i & ~bypass_c & (~fifo_full | shadow_we_i);
         cmp_entry = bypass_c ? main_entry : head_entry;
         cause_c[0] = (pop_c | bypass_c) & (cmp_entry != shadow_entry);
         cause_c[1] = shadow_we_i & fifo_empty & ~main_we_i;
         cause_c[2] = main_we_i & fifo_full & ~shadow_we_i;
         cause_c[3] = ~fifo_empty & ~pop_c & (age_q == AgeW'(TimeoutCycles - 1));
      end
   end

   assign detect_c = |cause_c;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= COMPARE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // FSM next state: one FLUSH cycle, then HoldoffCycles of HOLDOFF
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         COMPARE: begin
            if (detect_c) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            hold_d  = '0;
            state_d = (HoldoffCycles == 0) ? COMPARE : HOLDOFF;
         end
         HOLDOFF: begin
            if (hold_q == HoldW'(HoldoffCycles - 1)) begin
               state_d = COMPARE;
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         default: state_d = COMPARE;
      endcase
   end

   // FIFO storage; stale contents are harmless once pointers are cleared
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem[wr_ptr_q] <= main_entry;
      end
   end

   // FIFO pointers, level and head-age tracking; cleared on entry to FLUSH
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         age_q    <= '0;
      end else if (detect_c) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         age_q    <= '0;
      end else if (state_q == COMPARE) begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({push_c, pop_c})
            2'b10:   level_q <= level_q + LevelW'(1);
            2'b01:   level_q <= level_q - LevelW'(1);
            default: level_q <= level_q;
         endcase
         age_q <= (pop_c | fifo_empty) ? '0 : age_q + AgeW'(1);
      end
   end

   // Captured cause, saturating mismatch count and registered rollback pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cause_q    <= '0;
         cnt_q      <= '0;
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= (state_d == FLUSH);
         if (detect_c) begin
            cause_q <= cause_c;
            if (cnt_q != 8'hFF) begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

   assign comparator_mismatch_o = mismatch_q;
   assign mismatch_cause_o      = cause_q;
   assign mismatch_cnt_o        = cnt_q;
   assign fifo_level_o          = level_q;

endmodule

// File: doc/ibex_rf_wb_comparator.md
IBEX_RF_WB_COMPARATOR -- requirements
Module: ibex_rf_wb_comparator

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, the writeback data width.
REQ-002 The block SHALL have parameter Depth, default 4, the main-writeback FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter TimeoutCycles, default 16, the maximum age of the FIFO head entry.
REQ-004 The block SHALL have parameter HoldoffCycles, default 3, the post-mismatch ignore window.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port clk_i, input, 1, clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have ports main_we_i, main_waddr_i, main_wdata_i, inputs, widths 1/5/DataWidth, the main core register-file write port.
REQ-009 The block SHALL have ports shadow_we_i, shadow_waddr_i, shadow_wdata_i, inputs, widths 1/5/DataWidth, the lagging shadow core write port.
REQ-010 The block SHALL have port comparator_mismatch_o, output, 1, the rollback request feeding the register-file restore input.
REQ-011 The block SHALL have port mismatch_cause_o, output, 4, the captured cause: [0] addr/data, [1] underflow, [2] overflow, [3] timeout.
REQ-012 The block SHALL have port mismatch_cnt_o, output, 8, a saturating count of detected mismatches.
REQ-013 The block SHALL have port fifo_level_o, output, $clog2(Depth)+1, the number of FIFO entries.

Function
REQ-014 The FSM SHALL have states COMPARE, FLUSH and HOLDOFF.
REQ-015 In COMPARE, main_we_i SHALL push {waddr, wdata}; shadow_we_i SHALL pop the head and compare both fields.
REQ-016 A write to address 0 SHALL be compared like any other address.
REQ-017 With the FIFO empty and both write enables high in the same cycle, the shadow write SHALL be compared directly against the main inputs, with no push and no underflow.
REQ-018 With the FIFO full and both write enables high, the block SHALL pop then push, with no overflow.
REQ-019 A differing address or data SHALL set cause[0].
REQ-020 shadow_we_i with the FIFO empty and main_we_i low SHALL set cause[1].
REQ-021 main_we_i with the FIFO full and shadow_we_i low SHALL set cause[2], and the entry SHALL be dropped.
REQ-022 An age counter SHALL count the cycles the head is valid and not popped; it SHALL reset to 0 on each pop or when the FIFO is empty.
REQ-023 When the age counter reaches TimeoutCycles-1 with no pop, the block SHALL set cause[3].
REQ-024 Detection SHALL be combinational in cycle N; all causes detected in N SHALL be ORed into mismatch_cause_o at edge N+1.
REQ-025 On any detection in COMPARE, the FSM SHALL go to FLUSH at edge N+1.
REQ-026 comparator_mismatch_o SHALL equal 1 only while in FLUSH, for exactly one cycle.
REQ-027 On entering FLUSH, the FIFO SHALL be cleared (level 0) and the age counter cleared.
REQ-028 FLUSH SHALL be followed by HOLDOFF for exactly HoldoffCycles cycles, then COMPARE.
REQ-029 In FLUSH and HOLDOFF, both write ports SHALL be ignored: no push, pop or detection.
REQ-030 mismatch_cnt_o SHALL increment by 1 per FLUSH entry and saturate at 255.
REQ-031 mismatch_cause_o SHALL hold its value until the next detection overwrites it.
REQ-032 Outputs SHALL be driven from flops or state decode only; there SHALL be no input-to-output combinational path.

Reset
REQ-033 Asserting rst_i SHALL immediately force state COMPARE, FIFO empty, age 0, comparator_mismatch_o 0, mismatch_cause_o 0, mismatch_cnt_o 0 and fifo_level_o 0.
REQ-034 Reset asserted during FLUSH or HOLDOFF SHALL abort the sequence, and comparison SHALL resume on the first edge after deassertion.

Verification
REQ-035 The bench SHALL cover: main writes x5=0xDEADBEEF, then the shadow repeats it 2 cycles later -> no mismatch, level 1->0.
REQ-036 The bench SHALL cover: main writes x3=0x1, shadow writes x3=0x2 -> comparator_mismatch_o high one cycle after the shadow write, cause=0001, cnt=1, level=0.
REQ-037 The bench SHALL cover: FIFO empty, simultaneous equal writes to x7 -> no mismatch, level stays 0; then a shadow-only write -> cause=0010.
REQ-038 The bench SHALL cover: 5 main writes with no shadow writes (Depth 4) -> cause=0100 on the fifth; next 3 cycles ignored; COMPARE on cycle 5 after the flush.
REQ-039 The bench SHALL cover: one main write with no shadow write for 16 cycles -> cause=1000, pulse exactly one cycle.
REQ-040 The bench SHALL cover: 260 forced mismatches -> mismatch_cnt_o=255; then rst_i pulsed mid-HOLDOFF -> all outputs 0 immediately.
